// File: rtl/switch_mcu_regfile_mp.sv
// switch_mcu_regfile_mp: 2W/N-R register file with sequential clear engine.
// Define SWITCH_MCU_REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module switch_mcu_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_gpr_wen_a,
    input  logic [ADDR_W-1:0]            in_gpr_waddr_a,
    input  logic [DATA_W-1:0]            in_gpr_wdata_a,
    input  logic                         in_gpr_wen_b,
    input  logic [ADDR_W-1:0]            in_gpr_waddr_b,
    input  logic [DATA_W-1:0]            in_gpr_wdata_b,
    input  logic [RD_PORTS-1:0]          in_gpr_ren,
    input  logic [RD_PORTS*ADDR_W-1:0]   in_gpr_raddr,
    output logic [RD_PORTS*DATA_W-1:0]   out_gpr_rdata,
    output logic [RD_PORTS-1:0]          out_gpr_rvalid,
    input  logic                         in_clr_req,
    output logic                         out_clr_busy,
    output logic                         out_clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                        state, state_n;
    logic [ADDR_W:0]               idx, idx_n;
    logic [DATA_W-1:0]             mem [DEPTH];
    logic                          busy, wen_a, wen_b;
    logic [ADDR_W-1:0]             ra;
    logic [DATA_W-1:0]             rv;
    logic [RD_PORTS*DATA_W-1:0]    rd_next;
    logic [RD_PORTS-1:0]           rv_next;

    assign busy  = state != IDLE;
    assign wen_a = in_gpr_wen_a && !busy && !(ZERO_REG != 0 && in_gpr_waddr_a == '0);
    assign wen_b = in_gpr_wen_b && !busy && !(ZERO_REG != 0 && in_gpr_waddr_b == '0);

    always_comb begin
        state_n = state == IDLE  ? (in_clr_req ? CLEAR : IDLE) :
                  state == CLEAR ? (idx == {1'b0, {ADDR_W{1'b1}}} ? DONE : CLEAR) : IDLE;
        idx_n   = state == IDLE ? '0 : state == CLEAR ? idx + 1'b1 : idx;
    end

    always_comb begin
        rd_next = '0;
        rv_next = '0;
        ra      = '0;
        rv      = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            ra = in_gpr_raddr[k*ADDR_W +: ADDR_W];
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
            rv = (wen_b && in_gpr_waddr_b == ra) ? in_gpr_wdata_b :
                 (wen_a && in_gpr_waddr_a == ra) ? in_gpr_wdata_a : mem[ra];
`else
            rv = mem[ra];
`endif
            rv = (ZERO_REG != 0 && ra == '0) ? '0 : rv;
            rv_next[k] = in_gpr_ren[k] && !busy;
            rd_next[k*DATA_W +: DATA_W] = rv_next[k] ? rv : '0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state          <= IDLE;
            idx            <= '0;
            out_gpr_rdata  <= '0;
            out_gpr_rvalid <= '0;
            out_clr_busy   <= 1'b0;
            out_clr_done   <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            out_gpr_rdata  <= rd_next;
            out_gpr_rvalid <= rv_next;
            out_clr_busy   <= state_n != IDLE;
            out_clr_done   <= state_n == DONE;
        end
    end

    // Port B is applied last so it wins a same-address collision.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[idx[ADDR_W-1:0]] <= '0;
        end else begin
            if (wen_a) mem[in_gpr_waddr_a] <= in_gpr_wdata_a;
            if (wen_b) mem[in_gpr_waddr_b] <= in_gpr_wdata_b;
        end
    end
endmodule

// File: tb/tb_switch_mcu_regfile_mp.sv
// tb_switch_mcu_regfile_mp: directed self-checking bench for switch_mcu_regfile_mp.
module tb_switch_mcu_regfile_mp;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_gpr_wen_a = 1'b0;
    logic [4:0]  in_gpr_waddr_a = '0;
    logic [31:0] in_gpr_wdata_a = '0;
    logic        in_gpr_wen_b = 1'b0;
    logic [4:0]  in_gpr_waddr_b = '0;
    logic [31:0] in_gpr_wdata_b = '0;
    logic [1:0]  in_gpr_ren = '0;
    logic [9:0]  in_gpr_raddr = '0;
    logic [63:0] out_gpr_rdata;
    logic [1:0]  out_gpr_rvalid;
    logic        in_clr_req = 1'b0;
    logic        out_clr_busy;
    logic        out_clr_done;

    int checks = 0;
    int errors = 0;
    int busy_cnt, done_cnt;
    logic rv_bad;

    switch_mcu_regfile_mp dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_gpr_wen_a(in_gpr_wen_a), .in_gpr_waddr_a(in_gpr_waddr_a), .in_gpr_wdata_a(in_gpr_wdata_a),
        .in_gpr_wen_b(in_gpr_wen_b), .in_gpr_waddr_b(in_gpr_waddr_b), .in_gpr_wdata_b(in_gpr_wdata_b),
        .in_gpr_ren(in_gpr_ren), .in_gpr_raddr(in_gpr_raddr),
        .out_gpr_rdata(out_gpr_rdata), .out_gpr_rvalid(out_gpr_rvalid),
        .in_clr_req(in_clr_req), .out_clr_busy(out_clr_busy), .out_clr_done(out_clr_done)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        in_gpr_wen_a = 1'b1; in_gpr_waddr_a = a; in_gpr_wdata_a = d;
        tick();
        in_gpr_wen_a = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a);
        in_gpr_ren = 2'b11; in_gpr_raddr = {a, a};
        tick();
        in_gpr_ren = 2'b00;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd2(5'(a));
            check(tag, {out_gpr_rdata, 6'b0, out_gpr_rvalid, 7'b0, out_clr_done}, {64'h0, 8'h03, 8'h00});
        end
    endtask

    task automatic wait_clear(input string tag);
        busy_cnt = 0; done_cnt = 0; rv_bad = 1'b0;
        for (int i = 0; i < 40 && out_clr_busy; i++) begin
            busy_cnt++;
            if (out_clr_done) done_cnt++;
            if (out_gpr_rvalid != 2'b00 || out_gpr_rdata != 64'h0) rv_bad = 1'b1;
            tick();
        end
        in_gpr_wen_a = 1'b0; in_gpr_ren = 2'b00;
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_reads_masked"}, 64'(rv_bad), 64'd0);
    endtask

    initial begin
        tick(); tick();
        check("reset_rdata", out_gpr_rdata, 64'h0);
        check("reset_flags", {out_gpr_rvalid, out_clr_busy, out_clr_done}, 4'b0000);
        in_rst = 1'b0;
        read_all_zero("post_reset_read");

        in_gpr_wen_a = 1'b1; in_gpr_waddr_a = 5'd3; in_gpr_wdata_a = 32'hDEADBEEF;
        in_gpr_wen_b = 1'b1; in_gpr_waddr_b = 5'd3; in_gpr_wdata_b = 32'h12345678;
        tick();
        in_gpr_wen_a = 1'b0; in_gpr_wen_b = 1'b0;
        rd2(5'd3);
        check("b_wins_collision", out_gpr_rdata, {2{32'h12345678}});

        in_gpr_wen_b = 1'b1; in_gpr_waddr_b = 5'd0; in_gpr_wdata_b = 32'hFFFFFFFF;
        wr_a(5'd0, 32'hFFFFFFFF);
        in_gpr_wen_b = 1'b0;
        rd2(5'd0);
        check("zero_reg_read", {out_gpr_rdata, 6'b0, out_gpr_rvalid}, {64'h0, 8'h03});

        wr_a(5'd5, 32'h11111111);
        in_gpr_wen_a = 1'b1; in_gpr_waddr_a = 5'd5; in_gpr_wdata_a = 32'hCAFEF00D;
        in_gpr_ren = 2'b01; in_gpr_raddr = {5'd0, 5'd5};
        tick();
        in_gpr_wen_a = 1'b0; in_gpr_ren = 2'b00;
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
        check("same_cycle_read", out_gpr_rdata[31:0], 64'hCAFEF00D);
`else
        check("same_cycle_read", out_gpr_rdata[31:0], 64'h11111111);
`endif
        rd2(5'd5);
        check("next_cycle_read", out_gpr_rdata, {2{32'hCAFEF00D}});

        wr_a(5'd7, 32'h00000007);
        in_gpr_ren = 2'b01; in_gpr_raddr = {5'd7, 5'd7};
        tick();
        in_gpr_ren = 2'b00;
        check("port1_disabled", {out_gpr_rdata, 6'b0, out_gpr_rvalid}, {32'h0, 32'h7, 8'h01});

        for (int a = 1; a < 32; a++) wr_a(5'(a), 32'(a));
        rd2(5'd31);
        check("fill_31", out_gpr_rdata, {2{32'd31}});

        in_clr_req = 1'b1;
        tick();
        in_clr_req = 1'b0;
        check("clear_start_busy", {out_clr_busy, out_clr_done}, 2'b10);
        in_gpr_wen_a = 1'b1; in_gpr_waddr_a = 5'd9; in_gpr_wdata_a = 32'hAAAA5555;
        in_gpr_ren = 2'b11; in_gpr_raddr = {5'd9, 5'd9};
        wait_clear("clear1");
        read_all_zero("after_clear_read");

        wr_a(5'd20, 32'h00000055);
        wr_a(5'd2, 32'h00000066);
        in_clr_req = 1'b1;
        tick();
        in_clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        check("abort_flags", {out_clr_busy, out_clr_done}, 2'b00);
        read_all_zero("after_abort_read");

        in_clr_req = 1'b1;
        tick();
        in_clr_req = 1'b0;
        check("reclear_busy", {out_clr_busy, out_clr_done}, 2'b10);
        wait_clear("clear2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
